// File: rtl/drain_if.sv
// Handshake bundle between the systolic array output, the drain block and
// the downstream matrix consumer.
interface drain_if #(
  parameter int M  = 3,
  parameter int DW = 8
);
  logic                  in_valid;
  logic [DW*M-1:0]       in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DW*M*M-1:0]     out_data;
  logic                  overflow;

  modport master (
    output in_valid, in_data, out_ready,
    input  out_valid, out_data, overflow
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output out_valid, out_data, overflow
  );
endinterface

// File: rtl/drain.sv
// Realigns skewed result lanes from an MxM systolic array, gathers M aligned
// rows into a matrix buffer and offers the matrix on a valid/ready handshake.
module drain #(
  parameter int M  = 3,
  parameter int DW = 8
) (
  input  logic   CLK,
  input  logic   RST,
  drain_if.slave bus
);
  localparam int RW = DW * M;
  localparam int CW = (M > 1) ? $clog2(M) : 1;
  localparam logic [CW-1:0] LAST = CW'(M - 1);

  typedef enum logic {COLLECT, FULL} state_e;

  logic [RW-1:0] row_data;
  logic          row_valid;

  // Lane i arrives i cycles late, so it needs M-1-i stages to line up with lane M-1.
  for (genvar i = 0; i < M; i++) begin : g_lane
    localparam int D = M - 1 - i;
    if (D == 0) begin : g_pass
      assign row_data[DW*i +: DW] = bus.in_data[DW*i +: DW];
    end else begin : g_dly
      logic [DW-1:0] pipe_q [D];
      logic [DW-1:0] pipe_d [D];

      always_comb begin
        pipe_d[0] = bus.in_data[DW*i +: DW];
        for (int k = 1; k < D; k++) pipe_d[k] = pipe_q[k-1];
      end

      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of block ordering.
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          for (int k = 0; k < D; k++) pipe_q[k] <= '0;
        end else begin
          pipe_q <= pipe_d;
        end
      end

      assign row_data[DW*i +: DW] = pipe_q[D-1];
    end
  end

  if (M > 1) begin : g_vld
    logic [M-2:0] vld_q;
    logic [M-2:0] vld_d;

    always_comb begin
      vld_d[0] = bus.in_valid;
      for (int k = 1; k < M - 1; k++) vld_d[k] = vld_q[k-1];
    end

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) vld_q <= '0;
      else     vld_q <= vld_d;
    end

    assign row_valid = vld_q[M-2];
  end else begin : g_novld
    assign row_valid = bus.in_valid;
  end

  state_e        state_q,     state_d;
  logic [CW-1:0] cnt_q,       cnt_d;
  logic          out_valid_q, out_valid_d;
  logic          overflow_q,  overflow_d;
  logic [RW-1:0] buf_q [M];
  logic [RW-1:0] buf_d [M];

  always_comb begin
    // NOTE: every next-state signal takes its hold value first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    overflow_d  = overflow_q;
    buf_d       = buf_q;

    unique case (state_q)
      COLLECT: begin
        if (row_valid) begin
          buf_d[cnt_q] = row_data;
          if (cnt_q == LAST) begin
            cnt_d       = '0;
            out_valid_d = 1'b1;
            state_d     = FULL;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      FULL: begin
        if (bus.out_ready) begin
          if (row_valid) begin
            // The accepted matrix frees the buffer in time to take this row as row 0.
            buf_d[0] = row_data;
            if (M == 1) begin
              out_valid_d = 1'b1;
            end else begin
              cnt_d       = CW'(1);
              out_valid_d = 1'b0;
              state_d     = COLLECT;
            end
          end else begin
            out_valid_d = 1'b0;
            state_d     = COLLECT;
          end
        end else if (row_valid) begin
          overflow_d = 1'b1;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= COLLECT;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      // NOTE: the matrix buffer is reset too, so out_data never shows a
      // stale matrix after reset.
      for (int r = 0; r < M; r++) buf_q[r] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
      buf_q       <= buf_d;
    end
  end

  always_comb begin
    for (int r = 0; r < M; r++) bus.out_data[RW*r +: RW] = buf_q[r];
  end

  assign bus.out_valid = out_valid_q;
  assign bus.overflow  = overflow_q;
endmodule

// File: doc/drain.md
Name: drain

Overview:
- Output-side counterpart of the input skew feeder for the MxM systolic array. The array emits result lanes skewed: lane i of a row arrives i cycles after lane 0.
- drain delays lane i by (M-1-i) cycles so each row is realigned. It collects M aligned rows into one result matrix buffer and presents the matrix on a valid/ready handshake to the downstream consumer.

Parameters:
- M, 3, array dimension (lanes per row, rows per matrix); M>=1.
- DW, 8, data width per lane.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- in_valid  input  1  qualifies lane 0 of a skewed row in the current cycle; lane i of that row is sampled i cycles later, with no separate qualifier.
- in_data  input  DW*M  skewed lanes; lane i = in_data[DW*i +: DW].
- out_valid  output  1  result matrix available.
- out_ready  input  1  consumer accepts the matrix when out_valid && out_ready.
- out_data  output  DW*M*M  matrix; row r = out_data[DW*M*r +: DW*M], lane i of row r = out_data[DW*M*r + DW*i +: DW].
- overflow  output  1  sticky: an aligned row was dropped.

Behaviour:
- Deskew stage:
  - Lane i passes through M-1-i registers.
  - Lane M-1 is unregistered.
  - in_valid passes through an M-1 deep shift register; its output is row_valid.
  - The aligned row is valid in cycle t+M-1 for in_valid asserted in cycle t.
  - M=1: no registers; row_valid = in_valid.
- Collector FSM, states COLLECT and FULL, with row counter cnt in 0..M-1.
- COLLECT:
  - On row_valid, write the aligned row into buffer row cnt.
  - If cnt==M-1: cnt<=0, out_valid<=1 and go to FULL. Otherwise cnt<=cnt+1.
- FULL:
  - out_valid=1; out_data holds stable until accepted.
  - out_ready=1, no row_valid: out_valid<=0, go to COLLECT.
  - out_ready=1 and row_valid in the same cycle: the row is written as row 0 of the next matrix, cnt<=1 and go to COLLECT. With M=1, stay in FULL with out_valid=1 and the new data.
  - out_ready=0 and row_valid: the row is dropped, overflow<=1, buffer unchanged.
- Latency: a matrix whose row 0 has in_valid in cycle t has out_valid high from cycle t+2M-1, when rows arrive back-to-back.
- out_data reflects buffer contents; unwritten rows hold their prior values. The consumer samples out_data only when out_valid=1.
- in_valid may be asserted on any cycle, including gapped rows. Rows are counted by row_valid only.
- overflow clears only on RST.
- RST (asynchronous, any time), all of the following go to 0:
  - delay registers and valid shift register
  - cnt, with state to COLLECT
  - out_valid, out_data, overflow
- A partial matrix or an in-flight skewed row at reset is discarded. There is no stale output after reset.

Test Plan:
Each case uses M=3, DW=8. Matrix A has rows [01,02,03], [04,05,06], [07,08,09], fed skewed: row r lane i in cycle r+i, in_valid in cycles 0-2.
1. Assert RST asynchronously mid-cycle -> out_valid=0, overflow=0, out_data=0 immediately; they stay 0 with no input.
2. Feed A with out_ready=1 -> out_valid high in cycle 5 only, out_data=0x090807060504030201, then low.
3. Feed A with out_ready=0 through cycle 15 -> out_valid=1 and out_data constant from cycle 5 to 15. Raise out_ready in cycle 16 -> out_valid=0 in cycle 17.
4. Feed A, hold out_ready=0, then feed matrix B = 0x11..19 in cycles 6-8 -> overflow=1 from cycle 9 and sticky; out_data stays A. After acceptance and RST, overflow=0.
5. Feed A then B back-to-back (in_valid cycles 0-5) with out_ready=1 -> out_valid pulses in cycles 5 and 8; cycle 8 out_data=0x191817161514131211; overflow=0.
6. Feed two rows of A, assert RST in cycle 3, then feed B from cycle 6 -> no out_valid for A; B is presented in cycle 11 with the correct data.
